axis_argmax_10: RTL

- Downstream consumer of the 10-output dot-product stage (axis_dot_20_10).
- Accepts one frame of 10 IEEE-754 single-precision scores on an AXI4-Stream input and returns one AXI4-Stream word holding the index of the largest score.
- This is the classifier decision at the end of the inference pipeline; the word goes to the DMA/host path.

---
 rtl/axis_argmax_10_pkg.sv | 22 ++
 rtl/axis_argmax_10_if.sv | 12 +
 rtl/axis_argmax_10_cmp.sv | 17 +
 rtl/axis_argmax_10.sv | 108 ++++++++++
 4 files changed

// File: rtl/axis_argmax_10_pkg.sv
// Shared types, flag bit positions and fp32 ordering helpers for the argmax stage.
package argmax_pkg;

  typedef enum logic {S_ACCEPT, S_SEND} argmax_state_t;

  typedef logic [31:0] fp32_t;

  localparam int unsigned FLAG_LEN_ERR = 31;
  localparam int unsigned FLAG_ALL_NAN = 30;

  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  // Maps an fp32 onto an unsigned key that sorts like the float value; -0 folds onto +0.
  function automatic logic [31:0] fp32_order_key(input fp32_t x);
    fp32_t v;
    v = (x == 32'h8000_0000) ? '0 : x;
    return v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

endpackage

// File: rtl/axis_argmax_10_if.sv
// AXI4-Stream bundle used by the argmax stage and its neighbours.
interface axis_argmax_10_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/axis_argmax_10_cmp.sv
// Decides whether a candidate score replaces the running best (NaN never wins, ties keep the old).
module fp32_max_cmp
  import argmax_pkg::*;
(
  input  fp32_t       cand,
  input  logic [31:0] best_key,
  input  logic        have_best,
  output logic        take,
  output logic [31:0] cand_key
);

  always_comb begin
    cand_key = fp32_order_key(cand);
    take     = !fp32_is_nan(cand) && (!have_best || (cand_key > best_key));
  end

endmodule

// File: rtl/axis_argmax_10.sv
// Frame-wise argmax over fp32 scores; emits one registered index/flags word per frame.
module axis_argmax_10
  import argmax_pkg::*;
#(
  parameter int unsigned N     = 10,
  parameter int unsigned IDX_W = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  localparam int unsigned CNT_W    = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  argmax_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      best_key_q, best_key_d;
  logic             have_best_q, have_best_d;
  logic [31:0]      out_data_q, out_data_d;

  logic        take;
  logic [31:0] cand_key;

  fp32_max_cmp u_cmp (
    .cand      (INPUT_AXIS_TDATA),
    .best_key  (best_key_q),
    .have_best (have_best_q),
    .take      (take),
    .cand_key  (cand_key)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_idx_d  = best_idx_q;
    best_key_d  = best_key_q;
    have_best_d = have_best_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      S_ACCEPT: begin
        if (INPUT_AXIS_TVALID) begin
          count_d = count_q + CNT_W'(1);
          if (take) begin
            best_idx_d  = IDX_W'(count_q);
            best_key_d  = cand_key;
            have_best_d = 1'b1;
          end
          // Frame closes on TLAST or on the Nth word; extra words wait for the next frame.
          if (INPUT_AXIS_TLAST || (count_q == LAST_CNT)) begin
            state_d    = S_SEND;
            out_data_d = '0;
            if (have_best_d) begin
              out_data_d[IDX_W-1:0] = best_idx_d;
            end else begin
              out_data_d[FLAG_ALL_NAN] = 1'b1;
            end
            out_data_d[FLAG_LEN_ERR] = !(INPUT_AXIS_TLAST && (count_q == LAST_CNT));
          end
        end
      end
      S_SEND: begin
        if (OUTPUT_AXIS_TREADY) begin
          state_d     = S_ACCEPT;
          count_d     = '0;
          best_idx_d  = '0;
          best_key_d  = '0;
          have_best_d = 1'b0;
          out_data_d  = '0;
        end
      end
      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_ACCEPT;
      count_q     <= '0;
      best_idx_q  <= '0;
      best_key_q  <= '0;
      have_best_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_idx_q  <= best_idx_d;
      best_key_q  <= best_key_d;
      have_best_q <= have_best_d;
      out_data_q  <= out_data_d;
    end
  end

  assign INPUT_AXIS_TREADY  = (state_q == S_ACCEPT);
  assign OUTPUT_AXIS_TVALID = (state_q == S_SEND);
  assign OUTPUT_AXIS_TLAST  = (state_q == S_SEND);
  assign OUTPUT_AXIS_TDATA  = out_data_q;

endmodule
